// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers build the window, a
// two-stage pipeline thresholds |Gx|+|Gy| and emits one RGB565 word per pixel.
module sobel_edge_stream #(
  parameter int         CNT_COL_MAX = 1023,
  parameter int         CNT_ROW_MAX = 767,
  parameter logic [7:0] THR         = 8'd12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dip_en,
  input  logic [7:0]  dip_data,
  output logic        data_en,
  output logic [7:0]  p11,
  output logic [7:0]  p12,
  output logic [7:0]  p13,
  output logic [7:0]  p21,
  output logic [7:0]  p22,
  output logic [7:0]  p23,
  output logic [7:0]  p31,
  output logic [7:0]  p32,
  output logic [7:0]  p33,
  output logic        sdram_wr_en,
  output logic [15:0] sdram_wr_data
);

  localparam int CW = (CNT_COL_MAX > 0) ? $clog2(CNT_COL_MAX + 1) : 1;
  localparam int RW = (CNT_ROW_MAX > 0) ? $clog2(CNT_ROW_MAX + 1) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(CNT_COL_MAX);
  localparam logic [RW-1:0] ROW_LAST = RW'(CNT_ROW_MAX);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [7:0] line_a [0:CNT_COL_MAX];
  logic [7:0] line_b [0:CNT_COL_MAX];
  logic [7:0] rd_a;
  logic [7:0] rd_b;

  logic        valid;
  logic        s1_en;
  logic        s1_valid;
  logic signed [11:0] gx_q;
  logic signed [11:0] gy_q;

  logic [11:0] gx_pos;
  logic [11:0] gx_neg;
  logic [11:0] gy_pos;
  logic [11:0] gy_neg;
  logic signed [11:0] gx_c;
  logic signed [11:0] gy_c;
  logic [10:0] ax;
  logic [10:0] ay;
  logic [10:0] mag;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      col <= '0;
      row <= '0;
    end else if (dip_en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Asynchronous read: the window register captures the old entry in the
  // same edge that overwrites it, giving read-before-write at one address.
  assign rd_a = line_a[col];
  assign rd_b = line_b[col];

  always_ff @(posedge clk) begin
    if (!rst_n && dip_en) begin
      line_b[col] <= rd_a;
      line_a[col] <= dip_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      data_en <= 1'b0;
      valid   <= 1'b0;
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else begin
      data_en <= dip_en;
      if (dip_en) begin
        p11 <= p12; p12 <= p13; p13 <= rd_b;
        p21 <= p22; p22 <= p23; p23 <= rd_a;
        p31 <= p32; p32 <= p33; p33 <= dip_data;
        valid <= (int'(row) >= 2) && (int'(col) >= 2);
      end
    end
  end

  always_comb begin
    gx_pos = {4'b0, p13} + {3'b0, p23, 1'b0} + {4'b0, p33};
    gx_neg = {4'b0, p11} + {3'b0, p21, 1'b0} + {4'b0, p31};
    gy_pos = {4'b0, p31} + {3'b0, p32, 1'b0} + {4'b0, p33};
    gy_neg = {4'b0, p11} + {3'b0, p12, 1'b0} + {4'b0, p13};
    gx_c   = $signed(gx_pos) - $signed(gx_neg);
    gy_c   = $signed(gy_pos) - $signed(gy_neg);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_en    <= 1'b0;
      s1_valid <= 1'b0;
      gx_q     <= '0;
      gy_q     <= '0;
    end else begin
      s1_en    <= data_en;
      s1_valid <= valid;
      gx_q     <= gx_c;
      gy_q     <= gy_c;
    end
  end

  always_comb begin
    ax  = gx_q[11] ? 11'(-gx_q) : 11'(gx_q);
    ay  = gy_q[11] ? 11'(-gy_q) : 11'(gy_q);
    mag = ax + ay;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sdram_wr_en   <= 1'b0;
      sdram_wr_data <= '0;
    end else begin
      sdram_wr_en <= s1_en;
      if (s1_en) begin
        sdram_wr_data <= (s1_valid && (mag > {3'b000, THR})) ? '1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Scoreboard bench for sobel_edge_stream on a reduced 300x8 frame; a bench-side
// image model supplies expected windows and results.
module tb_sobel_edge_stream;

  localparam int COLS = 300;
  localparam int ROWS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dip_en = 1'b0;
  logic [7:0]  dip_data = '0;
  logic        data_en;
  logic [7:0]  p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic        sdram_wr_en;
  logic [15:0] sdram_wr_data;

  sobel_edge_stream #(
    .CNT_COL_MAX(COLS - 1),
    .CNT_ROW_MAX(ROWS - 1),
    .THR(8'd12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dip_en(dip_en), .dip_data(dip_data),
    .data_en(data_en),
    .p11(p11), .p12(p12), .p13(p13),
    .p21(p21), .p22(p22), .p23(p23),
    .p31(p31), .p32(p32), .p33(p33),
    .sdram_wr_en(sdram_wr_en), .sdram_wr_data(sdram_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          stamp;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          stamp;
    logic        chk;
    logic [71:0] win;
    logic [7:0]  pix;
  } win_t;

  wr_t  wr_q[$];
  win_t win_q[$];

  int   vectors = 0;
  int   miscompares = 0;
  int   wr_count = 0;
  logic mon_on = 1'b0;

  logic [7:0] img [0:ROWS-1][0:COLS-1];
  int mr = 0;
  int mc = 0;

  function automatic logic [15:0] sobel_ref(int r, int c);
    int a [3][3];
    int gx, gy, mag;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        a[i][j] = int'(img[r-2+i][c-2+j]);
    gx = (a[0][2] + 2*a[1][2] + a[2][2]) - (a[0][0] + 2*a[1][0] + a[2][0]);
    gy = (a[2][0] + 2*a[2][1] + a[2][2]) - (a[0][0] + 2*a[0][1] + a[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 12) ? 16'hFFFF : 16'h0000;
  endfunction

  // Called at posedge+1; the pixel is sampled at the following edge.
  task automatic send(input logic [7:0] d, input int gap);
    wr_t  w;
    win_t v;
    img[mr][mc] = d;
    dip_en   = 1'b1;
    dip_data = d;
    w.stamp = cyc;
    v.stamp = cyc;
    v.pix   = d;
    if (mr >= 2 && mc >= 2) begin
      w.data = sobel_ref(mr, mc);
      v.chk  = 1'b1;
      v.win  = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
    end else begin
      w.data = 16'h0000;
      v.chk  = 1'b0;
      v.win  = '0;
    end
    wr_q.push_back(w);
    win_q.push_back(v);
    if (mc == COLS - 1) begin
      mc = 0;
      mr = (mr == ROWS - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
    @(posedge clk); #1;
    dip_en = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain_and_count(input int base, input string tag);
    for (int k = 0; k < 20 && wr_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    vectors++;
    assert (wr_q.size() === 0) else begin
      miscompares++;
      $error("FAIL %s_drain observed=%0d pending expected=0", tag, wr_q.size());
    end
    vectors++;
    assert ((wr_count - base) === COLS * ROWS) else begin
      miscompares++;
      $error("FAIL %s_count observed=%0d expected=%0d", tag, wr_count - base, COLS * ROWS);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic exp_de;
    logic exp_wr;
    win_t v;
    wr_t  w;
    if (mon_on) begin
      exp_de = (win_q.size() > 0) && (win_q[0].stamp + 1 == cyc);
      vectors++;
      assert (data_en === exp_de) else begin
        miscompares++;
        $error("FAIL data_en cyc=%0d observed=%b expected=%b", cyc, data_en, exp_de);
      end
      if (exp_de) begin
        v = win_q.pop_front();
        vectors++;
        assert (p33 === v.pix) else begin
          miscompares++;
          $error("FAIL p33 cyc=%0d observed=%h expected=%h", cyc, p33, v.pix);
        end
        if (v.chk) begin
          vectors++;
          assert ({p11, p12, p13, p21, p22, p23, p31, p32, p33} === v.win) else begin
            miscompares++;
            $error("FAIL window cyc=%0d observed=%h expected=%h", cyc,
                   {p11, p12, p13, p21, p22, p23, p31, p32, p33}, v.win);
          end
        end
      end

      exp_wr = (wr_q.size() > 0) && (wr_q[0].stamp + 3 == cyc);
      vectors++;
      assert (sdram_wr_en === exp_wr) else begin
        miscompares++;
        $error("FAIL wr_en cyc=%0d observed=%b expected=%b", cyc, sdram_wr_en, exp_wr);
      end
      if (sdram_wr_en === 1'b1) wr_count++;
      if (exp_wr) begin
        w = wr_q.pop_front();
        vectors++;
        assert (sdram_wr_data === w.data) else begin
          miscompares++;
          $error("FAIL wr_data cyc=%0d observed=%h expected=%h", cyc, sdram_wr_data, w.data);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int c0;

    // Reset held with strobe activity: everything must stay cleared.
    repeat (10) begin
      @(posedge clk); #1;
      dip_en   = ~dip_en;
      dip_data = 8'($urandom);
    end
    @(negedge clk);
    vectors++;
    assert (data_en === 1'b0) else begin
      miscompares++; $error("FAIL rst_data_en observed=%b expected=0", data_en);
    end
    vectors++;
    assert (sdram_wr_en === 1'b0) else begin
      miscompares++; $error("FAIL rst_wr_en observed=%b expected=0", sdram_wr_en);
    end
    vectors++;
    assert ({p11, p12, p13, p21, p22, p23, p31, p32, p33} === 72'h0) else begin
      miscompares++;
      $error("FAIL rst_window observed=%h expected=0", {p11, p12, p13, p21, p22, p23, p31, p32, p33});
    end
    vectors++;
    assert (sdram_wr_data === 16'h0000) else begin
      miscompares++; $error("FAIL rst_wr_data observed=%h expected=0000", sdram_wr_data);
    end
    @(posedge clk); #1;
    rst_n  = 1'b0;
    dip_en = 1'b0;
    mon_on = 1'b1;

    // Ramp, sparse strobes: wrap 255->0 inside the line produces edges.
    base = wr_count;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        send(8'(c), 1);
    drain_and_count(base, "ramp");

    // Threshold boundary: 0->3 steps give mag 12; a 3/4 right column gives 14
    // (Sobel magnitudes are always even, so 14 is the first value above 12).
    base = wr_count;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        send((c >= 200) ? ((r >= 4) ? 8'd4 : 8'd3) :
             ((c >= 50 && c < 150) ? 8'd3 : 8'd0), 1);
    drain_and_count(base, "thresh");

    // Horizontal edge, back-to-back strobes.
    base = wr_count;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        send((r < 4) ? 8'd0 : 8'd100, 0);
    drain_and_count(base, "horiz");

    // Mid-frame reset at (5,100) with results still in flight.
    for (int i = 0; i < 5 * COLS + 100; i++)
      send(8'($urandom), 0);
    c0 = cyc;
    rst_n  = 1'b1;
    dip_en = 1'b0;
    while (wr_q.size() > 0 && wr_q[wr_q.size()-1].stamp >= c0 - 2) void'(wr_q.pop_back());
    while (win_q.size() > 0 && win_q[win_q.size()-1].stamp >= c0) void'(win_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    vectors++;
    assert (data_en === 1'b0 && sdram_wr_en === 1'b0) else begin
      miscompares++;
      $error("FAIL midrst_strobes observed=%b%b expected=00", data_en, sdram_wr_en);
    end
    vectors++;
    assert (sdram_wr_data === 16'h0000) else begin
      miscompares++; $error("FAIL midrst_wr_data observed=%h expected=0000", sdram_wr_data);
    end
    rst_n = 1'b0;
    mr = 0;
    mc = 0;
    @(posedge clk); #1;

    // Fresh frame after reset restarts at (0,0).
    base = wr_count;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        send(8'($urandom), 1);
    drain_and_count(base, "post_rst");

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
